// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// and buffers in-order responses into a small queue presented to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW     = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_last_pc;
  logic [CW-1:0] r_q_cnt;
  logic [CW-1:0] r_fl_cnt;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_q_rd;
  logic [AW-1:0] r_q_wr;
  logic [AW-1:0] r_fl_rd;
  logic [AW-1:0] r_fl_wr;
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_fl_pc  [DEPTH];

  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_keep;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic [CW-1:0] w_fl_cnt_nxt;
  logic [CW-1:0] w_discard_nxt;
  logic [31:0]   w_redir_pc;

  // Handshakes: a request transfers when o_imem_req && i_imem_gnt; a word leaves the
  // queue when o_valid && i_ready. Both sides hold their payload until the transfer.
  assign w_redir_pc = i_redirect_pc & ~32'h3;
  assign o_valid    = (r_q_cnt != '0);
  assign o_inst     = o_valid ? r_q_inst[r_q_rd] : NOP;
  assign o_pc       = o_valid ? r_q_pc[r_q_rd] : r_last_pc;
  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc & ~32'h3;

  always_comb begin
    w_occ         = {1'b0, r_q_cnt} + {1'b0, r_fl_cnt};
    w_req         = (r_state != BOOT) && (w_occ < CREDIT);
    w_gnt         = w_req && i_imem_gnt;
    w_rsp         = i_imem_rvalid && (r_fl_cnt != '0);
    w_keep        = w_rsp && !i_redirect && (r_discard == '0);
    w_pop         = o_valid && i_ready && !i_redirect;
    w_fl_cnt_nxt  = r_fl_cnt + CW'(w_gnt) - CW'(w_rsp);
    w_discard_nxt = r_discard;
    // Everything still outstanding after a redirect belongs to the old stream.
    if (i_redirect) begin
      w_discard_nxt = w_fl_cnt_nxt;
    end else if (w_rsp && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      default: w_state_nxt = (w_discard_nxt != '0) ? FLUSH : RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VEC;
      r_last_pc <= RESET_VEC;
      r_q_cnt   <= '0;
      r_q_rd    <= '0;
      r_q_wr    <= '0;
      r_fl_cnt  <= '0;
      r_fl_rd   <= '0;
      r_fl_wr   <= '0;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_pc <= o_pc;
      r_fl_cnt  <= w_fl_cnt_nxt;
      r_discard <= w_discard_nxt;
      if (w_gnt) r_fl_wr <= r_fl_wr + AW'(1);
      if (w_rsp) r_fl_rd <= r_fl_rd + AW'(1);
      if (i_redirect) begin
        r_pc    <= w_redir_pc;
        r_q_cnt <= '0;
        r_q_rd  <= '0;
        r_q_wr  <= '0;
      end else begin
        if (w_gnt)  r_pc   <= r_pc + 32'd4;
        if (w_pop)  r_q_rd <= r_q_rd + AW'(1);
        if (w_keep) r_q_wr <= r_q_wr + AW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

  // Payload storage carries no reset; occupancy counters qualify every read.
  always_ff @(posedge i_clk) begin
    if (w_gnt) r_fl_pc[r_fl_wr] <= r_pc & ~32'h3;
    if (w_keep) begin
      r_q_pc[r_q_wr]   <= r_fl_pc[r_fl_rd];
      r_q_inst[r_q_wr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side memory with in-order variable latency, a queue-level
// model of fetch/queue/flush behaviour, directed scenarios and randomized traffic.
module tb_fetch_unit;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  fetch_unit #(.RESET_VEC(RESET_VEC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_q[$];      // {pc, inst} words waiting for decode
  logic [31:0] fl_pc[$];      // PCs of granted, unanswered requests
  bit          fl_stale[$];   // request belongs to a stream killed by a redirect
  logic [31:0] m_pc, m_last_pc;
  bit          m_boot;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int gnt_pct, rdy_pct, rv_pct, redir_pct, lat_min, lat_max, redir_at, ptick;
  logic [31:0] force_rpc, salt;

  int          first_req_tick, grants;
  bit          fv_seen, stale_seen;
  logic [31:0] fv_pc, fv_inst;
  logic [31:0] g_log[$], pop_log[$], t_addr[$];
  bit          t_req[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); fl_pc.delete(); fl_stale.delete(); mem_q.delete();
    m_pc = RESET_VEC; m_last_pc = RESET_VEC; m_boot = 1'b1;
  endtask

  task automatic phase_start();
    ptick = 0; grants = 0; first_req_tick = -1; fv_seen = 0; stale_seen = 0;
    redir_at = -1; g_log.delete(); pop_log.delete(); t_addr.delete(); t_req.delete();
  endtask

  task automatic set_knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax; rv_pct = 100; redir_pct = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
    i_redirect = 0; i_redirect_pc = '0; i_ready = 0;
  endtask

  task automatic hard_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Entered and left at a negedge: check outputs, drive inputs, advance the model.
  task automatic tick();
    bit          e_req, e_valid, g, rv, rd, ry, st, keep;
    logic [31:0] e_addr, e_inst, e_pc, rdata, rpc, rsp_pc;
    int          sel;
    e_req   = !m_boot && ((exp_q.size() + fl_pc.size()) < DEPTH);
    e_addr  = m_pc & ~32'h3;
    e_valid = exp_q.size() > 0;
    e_inst  = e_valid ? exp_q[0][31:0] : NOP;
    e_pc    = e_valid ? exp_q[0][63:32] : m_last_pc;
    chk("req", 32'(o_imem_req), 32'(e_req));
    if (e_req) chk("addr", o_imem_addr, e_addr);
    chk("valid", 32'(o_valid), 32'(e_valid));
    chk("inst", o_inst, e_inst);
    chk("pc", o_pc, e_pc);

    if (o_imem_req && first_req_tick < 0) first_req_tick = ptick;
    if (o_valid && !fv_seen) begin fv_seen = 1; fv_pc = o_pc; fv_inst = o_inst; end
    if (o_valid && (o_pc == 32'h0 || o_pc == 32'h4 || o_inst == 32'h0 || o_inst == 32'h4))
      stale_seen = 1;
    t_addr.push_back(o_imem_addr);
    t_req.push_back(o_imem_req);

    g  = e_req && ($urandom_range(0, 99) < gnt_pct);
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(0, 99) < rv_pct);
    rdata = rv ? (mem_q[0].addr ^ salt) : $urandom;
    rd = (ptick == redir_at) || ($urandom_range(0, 99) < redir_pct);
    sel = $urandom_range(0, 3);
    case (sel)
      0:       rpc = $urandom;
      1:       rpc = ($urandom & 32'h0000_0FFC) | 32'(($urandom_range(1, 3)));
      2:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: rpc = 32'($urandom_range(0, 255));
    endcase
    if (ptick == redir_at) rpc = force_rpc;
    ry = $urandom_range(0, 99) < rdy_pct;

    i_imem_gnt = g; i_imem_rvalid = rv; i_imem_rdata = rdata;
    i_redirect = rd; i_redirect_pc = rpc; i_ready = ry;
    if (g && o_imem_req) begin grants++; g_log.push_back(o_imem_addr); end
    if (o_valid && ry && !rd) pop_log.push_back(o_pc);

    // Model step: outstanding requests are tagged stale on redirect instead of counted.
    keep = 0; rsp_pc = '0;
    if (rv) begin
      rsp_pc = fl_pc.pop_front();
      st     = fl_stale.pop_front();
      keep   = !st && !rd;
      void'(mem_q.pop_front());
    end
    if (g) mem_q.push_back('{addr: e_addr, due: cyc + $urandom_range(lat_min, lat_max)});
    if (rd) begin
      exp_q.delete();
      foreach (fl_stale[i]) fl_stale[i] = 1;
      if (g) begin fl_pc.push_back(e_addr); fl_stale.push_back(1); end
      m_pc = rpc & ~32'h3;
    end else begin
      if (e_valid && ry) void'(exp_q.pop_front());
      if (keep) exp_q.push_back({rsp_pc, rdata});
      if (g) begin fl_pc.push_back(e_addr); fl_stale.push_back(0); m_pc = m_pc + 32'd4; end
    end
    m_last_pc = e_pc;
    m_boot = 0;

    @(posedge i_clk);
    cyc++;
    ptick++;
    @(negedge i_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    salt = '0; force_rpc = '0;
    set_knobs(100, 100, 1, 1);
    model_reset();
    @(negedge i_clk);

    // Zero-wait memory, addr as data: first request one cycle after BOOT.
    hard_reset(); phase_start(); set_knobs(100, 100, 1, 1);
    run(12);
    chk("p1_first_req_tick", 32'(first_req_tick), 32'd1);
    chk("p1_first_gnt_addr", (g_log.size() > 0) ? g_log[0] : 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 3; i++)
      chk("p1_pop_pc", (i < pop_log.size()) ? pop_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
    chk("p1_fv_inst", fv_inst, 32'h0);

    // Decode stalled: credits stop requests at DEPTH; one pop frees exactly one.
    hard_reset(); phase_start(); set_knobs(100, 0, 1, 1);
    run(10);
    chk("p2_grants_full", 32'(grants), 32'd2);
    chk("p2_req_low", 32'(o_imem_req), 32'd0);
    chk("p2_valid", 32'(o_valid), 32'd1);
    rdy_pct = 100; run(1);
    rdy_pct = 0;   run(6);
    chk("p2_grants_after_pop", 32'(grants), 32'd3);
    chk("p2_req_low_again", 32'(o_imem_req), 32'd0);

    // Latency 3, two in flight, redirect: both stale responses vanish.
    hard_reset(); phase_start(); set_knobs(100, 100, 3, 3);
    redir_at = 3; force_rpc = 32'h0000_0100;
    run(14);
    chk("p3_fv_seen", 32'(fv_seen), 32'd1);
    chk("p3_fv_pc", fv_pc, 32'h0000_0100);
    chk("p3_fv_inst", fv_inst, 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    hard_reset(); phase_start(); set_knobs(100, 0, 1, 1);
    redir_at = 2; force_rpc = 32'h0000_0040;
    run(12);
    chk("p4_gnt1", (g_log.size() > 1) ? g_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("p4_fv_pc", fv_pc, 32'h0000_0040);
    chk("p4_no_stale", 32'(stale_seen), 32'd0);

    // Unaligned redirect during BOOT, then PC wrap at the top of memory.
    hard_reset(); phase_start(); set_knobs(0, 100, 1, 1);
    redir_at = 0; force_rpc = 32'h0000_0203;
    run(4);
    chk("p5_boot_req", 32'(t_req[0]), 32'd0);
    chk("p5_req", 32'(t_req[1]), 32'd1);
    chk("p5_addr", t_addr[1], 32'h0000_0200);
    chk("p5_addr_held", t_addr[3], 32'h0000_0200);
    redir_at = 4; force_rpc = 32'hFFFF_FFFC;
    run(1);
    gnt_pct = 100;
    run(8);
    chk("p5_wrap_gnt0", (g_log.size() > 0) ? g_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("p5_wrap_gnt1", (g_log.size() > 1) ? g_log[1] : 32'hDEAD_BEEF, 32'h0);

    // Reset mid-stream with the queue full.
    hard_reset(); phase_start(); set_knobs(100, 0, 1, 1);
    run(8);
    chk("p6_full_valid", 32'(o_valid), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("p6_rst_valid", 32'(o_valid), 32'd0);
    chk("p6_rst_inst", o_inst, NOP);
    chk("p6_rst_req", 32'(o_imem_req), 32'd0);
    clear_inputs(); model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    phase_start(); set_knobs(100, 100, 1, 1);
    run(5);
    chk("p6_restart_tick", 32'(first_req_tick), 32'd1);
    chk("p6_restart_addr", (g_log.size() > 0) ? g_log[0] : 32'hDEAD_BEEF, RESET_VEC);

    // Randomized traffic.
    for (int blk = 0; blk < 20; blk++) begin
      if (blk % 5 == 4) hard_reset();
      phase_start();
      lat_min = 1;
      set_knobs($urandom_range(30, 100), $urandom_range(20, 100), 1, $urandom_range(1, 5));
      rv_pct    = $urandom_range(50, 100);
      redir_pct = $urandom_range(0, 8);
      salt      = $urandom;
      run(300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
